// File: rtl/spike_tx.sv
// Serializes a parallel word MSB-first onto a 4-phase data/req/ack link, one handshake per bit.
// Latency: per bit setup_cyc cycles to req rise, req falls 3 cycles after ack_in rises, next bit 3 cycles after ack_in falls.
// Backpressure: in_ready only in IDLE with synchronized ack low; in_valid while busy is ignored.
module spike_tx #(
    parameter int data_bits   = 4,
    parameter int setup_cyc   = 1,
    parameter int timeout_cyc = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [data_bits-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 data_out,
    output logic                 req_out,
    input  logic                 ack_in,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int TMO_W = $clog2(timeout_cyc + 2);
    localparam int CYC_W = (TMO_W > 4) ? TMO_W : 4;
    localparam int BIT_W = (data_bits > 1) ? $clog2(data_bits) : 1;
    localparam logic [CYC_W-1:0] SETUP_LAST = CYC_W'(setup_cyc - 1);
    localparam logic [CYC_W-1:0] TMO_LAST   = CYC_W'((timeout_cyc > 0) ? timeout_cyc - 1 : 0);
    localparam bit TMO_EN = (timeout_cyc != 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 ack_m;
    logic                 ack_s;
    logic [data_bits-1:0] shreg;
    logic [data_bits-1:0] shreg_nxt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_nxt;
    logic [CYC_W-1:0]     cyc_cnt;
    logic [CYC_W-1:0]     cyc_cnt_nxt;
    logic                 req_nxt;
    logic                 err_nxt;
    logic                 tmo_hit;

    // The current bit lives in the MSB of a flop, so data_out is glitch-free.
    assign data_out = shreg[data_bits-1];
    assign busy     = (state != IDLE);
    assign in_ready = (state == IDLE) && !ack_s;
    assign tmo_hit  = TMO_EN && (cyc_cnt == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ack_m       <= 1'b0;
            ack_s       <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            cyc_cnt     <= '0;
            req_out     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            ack_m       <= ack_in;
            ack_s       <= ack_m;
            shreg       <= shreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            cyc_cnt     <= cyc_cnt_nxt;
            req_out     <= req_nxt;
            timeout_err <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        cyc_cnt_nxt = cyc_cnt;
        req_nxt     = req_out;
        err_nxt     = timeout_err;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    shreg_nxt   = in_data;
                    bit_cnt_nxt = BIT_W'(data_bits - 1);
                    err_nxt     = 1'b0;
                    state_nxt   = SETUP;
                end
            end
            SETUP: begin
                if (cyc_cnt == SETUP_LAST) begin
                    req_nxt   = 1'b1;
                    state_nxt = REQ_HI;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            REQ_HI: begin
                // A real ack wins over a timeout landing on the same edge.
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = REQ_LO;
                end else if (tmo_hit) begin
                    req_nxt   = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (bit_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        shreg_nxt   = shreg << 1;
                        bit_cnt_nxt = bit_cnt - BIT_W'(1);
                        state_nxt   = SETUP;
                    end
                end else if (tmo_hit) begin
                    err_nxt   = 1'b1;
                    state_nxt = DRAIN;
                end else begin
                    cyc_cnt_nxt = cyc_cnt + CYC_W'(1);
                end
            end
            DRAIN: begin
                if (!ack_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (state_nxt != state) begin
            cyc_cnt_nxt = '0;
        end
    end

endmodule
